// File: rtl/aes128_decrypt_iter_if.sv
// Start/done request bus for the iterative AES-128 decryption core.
interface aes128_decrypt_iter_if;
    logic         Start;
    logic [127:0] CodedMessage;
    logic [127:0] CipherKey;
    logic         Busy;
    logic         Done;
    logic [127:0] DecodedMessage;

    modport master (
        output Start, CodedMessage, CipherKey,
        input  Busy, Done, DecodedMessage
    );

    modport slave (
        input  Start, CodedMessage, CipherKey,
        output Busy, Done, DecodedMessage
    );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round key 10 is produced by a forward expansion pass, then the key schedule
// is walked back down to round key 0 alongside the decryption rounds.
module aes128_decrypt_iter #(
    parameter int unsigned ROUNDS      = 10,
    parameter bit          DONE_STICKY = 1'b0
) (
    input  logic               Clk,
    input  logic               ResetN,
    aes128_decrypt_iter_if.slave bus
);

    if (ROUNDS != 10) begin : g_rounds_check
        $error("aes128_decrypt_iter: only ROUNDS=10 is supported");
    end

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = '0;
        p = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box built from the field inverse and the affine transform rather than tables.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- state transforms (byte n at [127-8n -: 8]) ----------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ---------------- registers ----------------
    state_t       state_q;
    logic [127:0] blk_q;
    logic [127:0] key_q;
    logic [127:0] ckey_q;
    logic [3:0]   rnd_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] dout_q;

    // ---------------- datapath ----------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  iw1, iw2, iw3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  sw_in, sw_d;
    logic [127:0] key_fwd_d;
    logic [127:0] key_inv_d;
    logic [127:0] isb_d;
    logic [127:0] round_d;

    // Next round keys and round result; forward and inverse schedules share one SubWord.
    always_comb begin
        {w0, w1, w2, w3} = key_q;
        iw3       = w3 ^ w2;
        iw2       = w2 ^ w1;
        iw1       = w1 ^ w0;
        sw_in     = (state_q == KEYEXP) ? w3 : iw3;
        sw_d      = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon(rnd_q), 24'h000000};
        f0        = w0 ^ sw_d;
        f1        = w1 ^ f0;
        f2        = w2 ^ f1;
        f3        = w3 ^ f2;
        key_fwd_d = {f0, f1, f2, f3};
        key_inv_d = {w0 ^ sw_d, iw1, iw2, iw3};
        isb_d     = inv_sub_bytes(inv_shift_rows(blk_q));
        round_d   = inv_mix_columns(isb_d ^ key_q);
    end

    // Control FSM with registered outputs; rnd_q doubles as the rcon index.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            blk_q   <= '0;
            key_q   <= '0;
            ckey_q  <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        blk_q   <= bus.CodedMessage;
                        key_q   <= bus.CipherKey;
                        ckey_q  <= bus.CipherKey;
                        rnd_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= KEYEXP;
                    end else if (!DONE_STICKY) begin
                        done_q  <= 1'b0;
                    end
                end
                KEYEXP: begin
                    key_q <= key_fwd_d;
                    if (rnd_q == 4'(ROUNDS)) state_q <= INIT;
                    else                     rnd_q   <= rnd_q + 4'd1;
                end
                INIT: begin
                    blk_q   <= blk_q ^ key_q;
                    key_q   <= key_inv_d;
                    rnd_q   <= rnd_q - 4'd1;
                    state_q <= ROUND;
                end
                ROUND: begin
                    blk_q <= round_d;
                    key_q <= key_inv_d;
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) state_q <= FINAL;
                end
                FINAL: begin
                    a_rk0_is_key: assert (key_q == ckey_q);
                    dout_q  <= isb_d ^ key_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Busy           = busy_q;
    assign bus.Done           = done_q;
    assign bus.DecodedMessage = dout_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter: pulse-Done and sticky-Done builds side by side.
module tb_aes128_decrypt_iter;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam int           LAT   = 21;

    logic Clk;
    logic ResetN;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   busy_cnt0 = 0;
    logic prev_done1 = 1'b0;

    aes128_decrypt_iter_if bus0 ();
    aes128_decrypt_iter_if bus1 ();

    aes128_decrypt_iter #(.ROUNDS(10), .DONE_STICKY(1'b0)) u_dut0 (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus0)
    );

    aes128_decrypt_iter #(.ROUNDS(10), .DONE_STICKY(1'b1)) u_dut1 (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Pulse-Done monitor: every Done-high sample must match the head of the queue.
    always @(negedge Clk) begin
        exp_t e;
        if (!ResetN) begin
            busy_cnt0 = 0;
        end else begin
            if (bus0.Busy) busy_cnt0++;
            if (bus0.Done) begin
                if (sb0.size() == 0) begin
                    chk("dut0_unexpected_done", 128'd1, 128'd0);
                end else begin
                    e = sb0.pop_front();
                    chk("dut0_plaintext", bus0.DecodedMessage, e.pt);
                    chk("dut0_done_cycle", 128'(cyc), 128'(e.due));
                    chk("dut0_busy_cycles", 128'(busy_cnt0), 128'(LAT));
                end
                busy_cnt0 = 0;
            end
        end
    end

    // Sticky-Done monitor: a completion is the rising edge of Done.
    always @(negedge Clk) begin
        exp_t e;
        if (ResetN && bus1.Done && !prev_done1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_done", 128'd1, 128'd0);
            end else begin
                e = sb1.pop_front();
                chk("dut1_plaintext", bus1.DecodedMessage, e.pt);
                chk("dut1_done_cycle", 128'(cyc), 128'(e.due));
            end
        end
        prev_done1 = bus1.Done;
    end

    // Called just after a negedge; Start is sampled at the next posedge (E0).
    task automatic issue(input int which, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt);
        exp_t e;
        e.pt  = pt;
        e.due = cyc + 1 + LAT;
        if (which == 0) begin
            bus0.CipherKey    = key;
            bus0.CodedMessage = ct;
            bus0.Start        = 1'b1;
            sb0.push_back(e);
        end else begin
            bus1.CipherKey    = key;
            bus1.CodedMessage = ct;
            bus1.Start        = 1'b1;
            sb1.push_back(e);
        end
        @(posedge Clk);
        @(negedge Clk);
        if (which == 0) bus0.Start = 1'b0;
        else            bus1.Start = 1'b0;
    endtask

    task automatic wait_done(input int which);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            seen = (which == 0) ? bus0.Done : bus1.Done;
        end
        chk(which == 0 ? "dut0_done_timeout" : "dut1_done_timeout", 128'(seen), 128'd1);
    endtask

    initial begin
        int hi_cnt;
        bus0.Start = 1'b0; bus0.CodedMessage = '0; bus0.CipherKey = '0;
        bus1.Start = 1'b0; bus1.CodedMessage = '0; bus1.CipherKey = '0;
        ResetN = 1'b1;
        #1 ResetN = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", 128'(bus0.Busy), 128'd0);
        chk("reset_done", 128'(bus0.Done), 128'd0);
        chk("reset_dout", bus0.DecodedMessage, 128'd0);
        chk("reset_done_sticky", 128'(bus1.Done), 128'd0);
        ResetN = 1'b1;
        @(negedge Clk);

        // App. B vector
        issue(0, KEY_B, CT_B, PT_B);
        wait_done(0);
        repeat (2) @(negedge Clk);

        // App. C.1 vector
        issue(0, KEY_C, CT_C, PT_C);
        wait_done(0);
        repeat (2) @(negedge Clk);

        // All-zero key, then back-to-back Start in the Done cycle
        issue(0, '0, CT_Z, 128'd0);
        wait_done(0);
        issue(0, KEY_B, CT_B, PT_B);
        chk("b2b_done_dropped", 128'(bus0.Done), 128'd0);
        chk("b2b_busy", 128'(bus0.Busy), 128'd1);
        wait_done(0);
        repeat (2) @(negedge Clk);

        // Start pulses and input changes while Busy must be ignored
        issue(0, KEY_B, CT_B, PT_B);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                bus0.CodedMessage = ~bus0.CodedMessage;
                bus0.CipherKey    = KEY_C;
            end
            bus0.Start = (k == 3 || k == 10 || k == 20);
            @(negedge Clk);
        end
        bus0.Start = 1'b0;
        wait_done(0);
        repeat (10) @(negedge Clk);

        // Asynchronous reset at cycle 13 of an operation
        issue(0, KEY_B, CT_B, PT_B);
        repeat (13) @(posedge Clk);
        #2 ResetN = 1'b0;
        #1;
        chk("abort_busy", 128'(bus0.Busy), 128'd0);
        chk("abort_done", 128'(bus0.Done), 128'd0);
        chk("abort_dout", bus0.DecodedMessage, 128'd0);
        sb0.delete();
        @(negedge Clk);
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);
        issue(0, KEY_C, CT_C, PT_C);
        wait_done(0);
        repeat (2) @(negedge Clk);

        // Sticky Done build
        issue(1, KEY_B, CT_B, PT_B);
        wait_done(1);
        hi_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (bus1.Done === 1'b1) hi_cnt++;
        end
        chk("sticky_hold_cycles", 128'(hi_cnt), 128'd50);
        chk("sticky_idle_busy", 128'(bus1.Busy), 128'd0);
        issue(1, KEY_C, CT_C, PT_C);
        chk("sticky_cleared_on_accept", 128'(bus1.Done), 128'd0);
        wait_done(1);
        repeat (5) @(negedge Clk);

        chk("sb0_drained", 128'(sb0.size()), 128'd0);
        chk("sb1_drained", 128'(sb1.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
